// File: rtl/vga_sampler_pkg.sv
// Shared types for the VGA pixel sampler.
// Frame tagging is enabled by VGA_SAMPLER_FRAME_TAG_EN.
package vga_sampler_pkg;

  localparam int TAG_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_e;

  typedef struct packed {
    logic hs;
    logic vs;
  } sample_hdr_t;

  typedef struct packed {
    logic             sof;
    logic [TAG_W-1:0] frame;
  } tag_t;

  localparam int HDR_W = $bits(sample_hdr_t);
  localparam int TAG_BITS = $bits(tag_t);

endpackage

// File: rtl/vga_sampler_fifo.sv
// Sample FIFO for the VGA pixel sampler.
// Push into a full FIFO is taken only alongside a pop.
module vga_sampler_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int FW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [FW-1:0] fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == FW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign fill_o  = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + FW'(1);
      2'b01:   cnt_d = cnt_q - FW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; empty entries are masked on the read side.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/vga_pixel_sampler.sv
// Decimating VGA pixel sampler with a frame-synchronised FSM.
// Optional frame tags via VGA_SAMPLER_FRAME_TAG_EN.
module vga_pixel_sampler
  import vga_sampler_pkg::*;
#(
  parameter int CW    = 8,
  parameter int DECIM = 4,
  parameter int DEPTH = 16
) (
  input  logic                         FPGA_Clock,
  input  logic                         FPGA_Reset_N,
  input  logic                         enable,
  input  logic                         single_frame,
  input  logic                         visible,
  input  logic                         VGA_HS,
  input  logic                         VGA_VS,
  input  logic [CW-1:0]                VGA_R,
  input  logic [CW-1:0]                VGA_G,
  input  logic [CW-1:0]                VGA_B,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3*CW+1:0]              out_data,
  output logic                         overflow,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fill
`ifdef VGA_SAMPLER_FRAME_TAG_EN
  ,
  output logic                         out_sof,
  output logic [TAG_W-1:0]             out_frame
`endif
);

  localparam int SW = 3 * CW + HDR_W;
`ifdef VGA_SAMPLER_FRAME_TAG_EN
  localparam int DW = SW + TAG_BITS;
`else
  localparam int DW = SW;
`endif
  localparam logic [7:0] LAST = 8'(DECIM - 1);

  state_e      state_q, state_d;
  logic        vs_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        vs_fall;
  logic        arm;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  sample_hdr_t hdr;

  assign vs_fall   = vs_q & ~VGA_VS;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = (state_q == CAPTURE) & visible & (cnt_q == LAST);
  assign overflow  = ovf_q;
  assign hdr.hs    = VGA_HS;
  assign hdr.vs    = VGA_VS;

  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ARMED;
          arm     = 1'b1;
        end
      end
      ARMED: begin
        if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (vs_fall && single_frame) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      arm     = 1'b0;
    end
  end

  // Counter advances on visible capture cycles and wraps on each push.
  always_comb begin
    cnt_d = cnt_q;
    if (vs_fall || arm) begin
      cnt_d = '0;
    end else if (state_q == CAPTURE && visible) begin
      cnt_d = push ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    if (arm) ovf_d = 1'b0;
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
    if (!FPGA_Reset_N) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= VGA_VS;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef VGA_SAMPLER_FRAME_TAG_EN
  logic             sof_q, sof_d;
  logic [TAG_W-1:0] frame_q, frame_d;
  tag_t             tag;

  // sof arms at the frame edge and is consumed by the first push.
  always_comb begin
    sof_d   = sof_q;
    frame_d = frame_q;
    if (push) sof_d = 1'b0;
    if (vs_fall && (state_q == ARMED || state_q == CAPTURE)) sof_d = 1'b1;
    if (vs_fall && state_q == CAPTURE) frame_d = frame_q + TAG_W'(1);
  end

  always_ff @(posedge FPGA_Clock or negedge FPGA_Reset_N) begin
    if (!FPGA_Reset_N) begin
      sof_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      sof_q   <= sof_d;
      frame_q <= frame_d;
    end
  end

  assign tag.sof   = sof_q;
  assign tag.frame = frame_q;
  assign din       = {hdr, VGA_R, VGA_G, VGA_B, tag};
  assign out_sof   = dout[TAG_W];
  assign out_frame = dout[TAG_W-1:0];
`else
  assign din = {hdr, VGA_R, VGA_G, VGA_B};
`endif

  assign out_data = dout[DW-1 -: SW];

  vga_sampler_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (FPGA_Clock),
    .rst_ni  (FPGA_Reset_N),
    .push_i  (push),
    .data_i  (din),
    .pop_i   (pop),
    .data_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

endmodule

// File: doc/vga_pixel_sampler.md
VGA_PIXEL_SAMPLER -- requirements
Module: vga_pixel_sampler

Interface
REQ-001 SHALL have parameter CW, default 8: width of each colour channel.
REQ-002 SHALL have parameter DECIM, default 4, legal range 1..255: number of visible cycles per captured sample.
REQ-003 SHALL have parameter DEPTH, default 16, power of 2 and at least 2: sample FIFO entries.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: FPGA_Clock  in  1  system clock, all logic on its rising edge.
REQ-005 SHALL provide FPGA_Reset_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL provide enable  in  1  capture enable.
REQ-007 SHALL provide single_frame  in  1  1 = capture one frame then stop; 0 = capture continuously.
REQ-008 SHALL provide visible  in  1  active-video qualifier.
REQ-009 SHALL provide VGA_HS  in  1  and  VGA_VS  in  1  sync inputs, both active-low.
REQ-010 SHALL provide VGA_R, VGA_G, VGA_B  in  CW each  pixel channels.
REQ-011 SHALL provide out_valid  out  1, out_ready  in  1, and out_data  out  3*CW+2  {HS,VS,R,G,B}, MSB first.
REQ-012 SHALL provide overflow  out  1 (sticky drop flag), done  out  1 (single frame complete) and fill  out  $clog2(DEPTH+1) (FIFO occupancy).

Function
REQ-013 SHALL use FSM states IDLE, ARMED, CAPTURE and DONE.
REQ-014 SHALL take these FSM transitions:
- IDLE to ARMED on enable=1.
- ARMED to CAPTURE on a VGA_VS falling edge, detected against a 1-cycle registered copy.
- CAPTURE to DONE on the next VS falling edge when single_frame=1; otherwise stay in CAPTURE.
- Any state to IDLE within 1 cycle when enable=0.
REQ-015 SHALL run the decimation counter only in CAPTURE and only while visible=1, holding its value while visible=0.
REQ-016 SHALL push a sample in the cycle the counter equals DECIM-1, then wrap the counter to 0; with DECIM=1, every visible cycle is pushed.
REQ-017 SHALL clear the decimation counter on each VS falling edge and on entry to ARMED.
REQ-018 SHALL form each pushed sample from the same-cycle input values.
REQ-019 SHALL assert out_valid the cycle after a push into an empty FIFO.
REQ-020 SHALL drive out_valid = FIFO not empty, with out_data showing the head entry and held stable while out_valid=1 and out_ready=0.
REQ-021 SHALL pop an entry when out_valid and out_ready are both 1.
REQ-022 SHALL accept a push into a full FIFO in a cycle with a simultaneous pop, leaving fill unchanged.
REQ-023 SHALL drop a push into a full FIFO with no pop, and set overflow to 1.
REQ-024 SHALL keep overflow at 1 until reset or an IDLE-to-ARMED transition.
REQ-025 SHALL hold done at 1 while in DONE and 0 otherwise.
REQ-026 SHALL keep the FIFO contents and keep draining them in DONE and IDLE.

Reset
REQ-027 SHALL, on FPGA_Reset_N=0, put the FSM in IDLE and clear the counter, FIFO pointers and VS history register.
REQ-028 SHALL drive these reset values: out_valid=0, overflow=0, done=0, fill=0 and out_data=0.
REQ-029 SHALL, when reset is asserted mid-capture, discard all queued samples, and SHALL leave the block in IDLE after release.

Configuration
REQ-030 SHALL, when VGA_SAMPLER_FRAME_TAG_EN is defined, add outputs out_sof (1 bit, 1 on the first sample of each frame) and out_frame (8 bits, a frame index incremented at each VS falling edge in CAPTURE and wrapping 255 to 0).
REQ-031 SHALL, in that configuration, store both tag values in the FIFO alongside the sample, and SHALL reset both to 0.
REQ-032 SHALL, when VGA_SAMPLER_FRAME_TAG_EN is not defined, have neither port nor any tag storage.

Structure
REQ-033 SHALL place the state enum, the sample struct type and the tag width constant (8) in package vga_sampler_pkg.
REQ-034 SHALL implement the FIFO as sub-module vga_sampler_fifo, with parameters for width and depth, push/pop, full/empty and fill.

Verification
REQ-035 SHALL cover basic capture: DECIM=4, enable=1, VS falling edge, then 16 visible cycles with R counting 0..15 -> R values 3, 7, 11, 15 appear in order.
REQ-036 SHALL cover gapped visible: visible=0 for 5 cycles after the 2nd visible cycle, DECIM=4 -> first sample is the 4th visible cycle, not the 4th clock.
REQ-037 SHALL cover overflow: DEPTH=16, out_ready=0, 20 samples pushed -> fill=16 and overflow=1, and popping returns samples 1..16.
REQ-038 SHALL cover full with simultaneous pop: FIFO full, out_ready=1 in the push cycle -> fill stays 16 and overflow stays 0.
REQ-039 SHALL cover single-frame mode: single_frame=1 over 2 VS falling edges -> done=1 after the 2nd, and no samples from the following frame.
REQ-040 SHALL cover reset mid-CAPTURE: reset asserted with fill=5 -> fill=0, out_valid=0 and IDLE; with the tag macro defined, out_frame=0 after reset.
